// File: rtl/sp_tx_pkg.sv
// Shared types and constants for the sensor-packet to DMA transmitter.
package sp_tx_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        OKRX = 2'd2,
        CRC  = 2'd3
    } state_t;

    // CRC-16/CCITT-FALSE defaults: MSB-first, non-reflected
    localparam logic [15:0] DEF_CRC_POLY = 16'h1021;
    localparam logic [15:0] DEF_CRC_INIT = 16'hFFFF;

    // Number of whole bytes needed to carry n status bits
    function automatic int ok_rx_bytes(input int n);
        return (n + 7) / 8;
    endfunction

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC-16 update by one byte, MSB-first, non-reflected.
module crc16_byte (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    input  logic [15:0] poly,
    output logic [15:0] crc_out
);

    logic [15:0] acc;

    // Shift the byte through the LFSR one bit at a time, MSB first
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so each loop step sees the previous one.
        acc = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            acc = acc[15] ? ((acc << 1) ^ poly) : (acc << 1);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/transmit_sp_frame_to_dma.sv
// Sensor-packet frame transmitter towards an Avalon-ST DMA sink.
// Frame = memory payload, ok_rx status bytes (LSB byte first), CRC-16.
// Build option: define SP_FRAME_CRC_EN to append the two CRC beats;
// without it the frame ends on the last status (or payload) byte.
module transmit_sp_frame_to_dma
    import sp_tx_pkg::*;
#(
    parameter int          SENSORS_NUMBER = 16,
    parameter logic [15:0] CRC_POLY       = DEF_CRC_POLY,
    parameter logic [15:0] CRC_INIT       = DEF_CRC_INIT
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            sot,
    input  logic [7:0]                                      mem_data,
    input  logic                                            mem_valid,
    input  logic                                            mem_eor,
    output logic                                            mem_ready,
    input  logic [(SENSORS_NUMBER > 0 ? SENSORS_NUMBER : 1)-1:0] ok_rx,
    output logic [7:0]                                      src_data,
    output logic                                            src_valid,
    input  logic                                            src_ready,
    output logic                                            src_sop,
    output logic                                            src_eop,
    output logic                                            busy
);

    localparam int OKB    = ok_rx_bytes(SENSORS_NUMBER);
    localparam int OK_W   = (SENSORS_NUMBER > 0) ? SENSORS_NUMBER : 1;
    localparam int SNAP_W = (OKB > 0) ? OKB * 8 : 8;
    localparam int CNT_W  = (OKB > 1) ? $clog2(OKB) : 1;
    localparam bit HAS_OK = (OKB > 0);
    localparam logic [CNT_W-1:0] LAST_CNT = (OKB > 0) ? CNT_W'(OKB - 1) : '0;

`ifdef SP_FRAME_CRC_EN
    localparam state_t TAIL = CRC;
`else
    localparam state_t TAIL = IDLE;
`endif

    state_t             state;
    state_t             state_nxt;
    logic               first_beat;
    logic [CNT_W-1:0]   byte_cnt;
    logic [SNAP_W-1:0]  ok_snap;
    logic [SNAP_W-1:0]  ok_pad;
    logic [7:0]         ok_byte;
    logic               last_ok;
    logic               fire;

    assign fire    = src_valid & src_ready;
    assign last_ok = (byte_cnt == LAST_CNT);
    assign ok_byte = ok_snap[{byte_cnt, 3'b000} +: 8];
    assign busy    = (state != IDLE);

    // Zero-extend the status flags to whole bytes
    always_comb begin
        ok_pad           = '0;
        ok_pad[OK_W-1:0] = ok_rx;
    end

`ifdef SP_FRAME_CRC_EN
    logic        crc_beat;
    logic [15:0] crc;
    logic [15:0] crc_next;

    crc16_byte u_crc (
        .crc_in  (crc),
        .data_in (src_data),
        .poly    (CRC_POLY),
        .crc_out (crc_next)
    );

    // CRC accumulator: seeded on sot, updated per payload/status beat, frozen in CRC
    always_ff @(posedge clk) begin
        if (rst) begin
            crc      <= CRC_INIT;
            crc_beat <= 1'b0;
        end else begin
            if (state == IDLE && sot) begin
                crc <= CRC_INIT;
            end else if ((state == MEM || state == OKRX) && fire) begin
                crc <= crc_next;
            end
            if (state == CRC && fire) begin
                crc_beat <= ~crc_beat;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking '<=' so all registers see pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (sot) state_nxt = MEM;
            MEM:  if (fire && mem_eor) state_nxt = HAS_OK ? OKRX : TAIL;
            OKRX: if (fire && last_ok) state_nxt = TAIL;
`ifdef SP_FRAME_CRC_EN
            CRC:  if (fire && crc_beat) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: MEM is a zero-latency pass-through of the memory stream
    always_comb begin
        src_data  = 8'h00;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        mem_ready = 1'b0;
        case (state)
            MEM: begin
                src_data  = mem_data;
                src_valid = mem_valid;
                src_sop   = first_beat;
                mem_ready = src_ready;
`ifndef SP_FRAME_CRC_EN
                src_eop   = !HAS_OK && mem_eor;
`endif
            end
            OKRX: begin
                src_data  = ok_byte;
                src_valid = 1'b1;
`ifndef SP_FRAME_CRC_EN
                src_eop   = last_ok;
`endif
            end
`ifdef SP_FRAME_CRC_EN
            CRC: begin
                src_data  = crc_beat ? crc[7:0] : crc[15:8];
                src_valid = 1'b1;
                src_eop   = crc_beat;
            end
`endif
            default: ;
        endcase
    end

    // Frame bookkeeping: sop flag and status byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            first_beat <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            if (state == IDLE && sot) begin
                first_beat <= 1'b1;
            end else if (state == MEM && fire) begin
                first_beat <= 1'b0;
            end
            if (state == OKRX && fire) begin
                byte_cnt <= last_ok ? '0 : byte_cnt + 1'b1;
            end
        end
    end

    // Status snapshot taken with the last payload byte
    always_ff @(posedge clk) begin
        // NOTE: data-only storage is left unreset; it is always written before it is read.
        if (state == MEM && fire && mem_eor) begin
            ok_snap <= ok_pad;
        end
    end

endmodule
